// File: rtl/pwm_mode_pkg.sv
// Shared types and default timing for the PWM mode link (transmitter and receiver).
// The receiver samples SAMPLE_POINT cycles after each rising edge and needs CONFIRM_PULSES repeats.
package pwm_mode_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_t;

  localparam int PERIOD_DEF     = 1050000;
  localparam int SHORT_HIGH_DEF = 50500;
  localparam int LONG_HIGH_DEF  = 95000;
  localparam int SAMPLE_POINT   = 75000;
  localparam int CONFIRM_PULSES = 5;

  // The default pulse widths must straddle the receiver sample point.
  localparam bit DEF_TIMING_OK = (SHORT_HIGH_DEF < SAMPLE_POINT) && (SAMPLE_POINT < LONG_HIGH_DEF);

  function automatic bit params_legal(input int period, input int short_high,
                                      input int long_high, input int cnt_w);
    return (short_high > 0) && (short_high < long_high) && (long_high < period) &&
           (cnt_w > 0) && (cnt_w < 63) && ((longint'(1) << cnt_w) > longint'(period));
  endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// Frame cycle counter with end-of-high and end-of-period flags; flags are combinational on the count.
// Counter holds at 0 while not running and wraps to 0 on the last cycle of the period.
module pwm_frame_timer #(
  parameter int PERIOD     = 200,
  parameter int SHORT_HIGH = 50,
  parameter int LONG_HIGH  = 150,
  parameter int CNT_W      = 21
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_long,
  output logic o_end_high,
  output logic o_end_period
);

  localparam logic [CNT_W-1:0] SHORT_LAST  = CNT_W'(SHORT_HIGH - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_HIGH - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_high_last;

  assign w_high_last  = i_long ? LONG_LAST : SHORT_LAST;
  assign o_end_high   = (r_cnt == w_high_last);
  assign o_end_period = (r_cnt == PERIOD_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_run || o_end_period) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pwm_mode_transmitter.sv
// PWM mode transmitter: first high output one cycle after ENABLE is sampled; frames always complete.
// Mode changes only at frame boundaries after MIN_REPEATS frames; PWM_TX_PULSE_COUNT_EN adds PULSE_COUNT.
module pwm_mode_transmitter
  import pwm_mode_pkg::*;
#(
  parameter int PERIOD      = PERIOD_DEF,
  parameter int SHORT_HIGH  = SHORT_HIGH_DEF,
  parameter int LONG_HIGH   = LONG_HIGH_DEF,
  parameter int MIN_REPEATS = CONFIRM_PULSES + 1,
  parameter int CNT_W       = 21
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        ENABLE,
  input  logic        MODE_SEL,
  output logic        AUX_OUTPUT,
  output logic        MODE_ACTIVE,
  output logic        FRAME_STROBE,
  output logic        SWITCH_BUSY
`ifdef PWM_TX_PULSE_COUNT_EN
  ,
  output logic [15:0] PULSE_COUNT
`endif
);

  localparam int REP_W = $clog2(MIN_REPEATS + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(MIN_REPEATS);

  if (!DEF_TIMING_OK || !params_legal(PERIOD, SHORT_HIGH, LONG_HIGH, CNT_W) || (MIN_REPEATS < 1))
  begin : g_bad_params
    $error("pwm_mode_transmitter: need 0 < SHORT_HIGH < LONG_HIGH < PERIOD < 2**CNT_W");
  end

  pwm_state_t       r_state, w_state_nxt;
  logic             r_mode, w_mode_nxt;
  logic [REP_W-1:0] r_rep, w_rep_nxt, w_rep_inc;
  logic             r_aux, w_aux_nxt;
  logic             r_strobe, w_strobe_nxt;
  logic             r_busy, w_busy_nxt;
  logic             w_run, w_end_high, w_end_period;

  assign w_run = (r_state != IDLE);

  pwm_frame_timer #(
    .PERIOD     (PERIOD),
    .SHORT_HIGH (SHORT_HIGH),
    .LONG_HIGH  (LONG_HIGH),
    .CNT_W      (CNT_W)
  ) u_timer (
    .i_clk        (CLOCK_50),
    .i_rst_n      (RESET_N),
    .i_run        (w_run),
    .i_long       (r_mode),
    .o_end_high   (w_end_high),
    .o_end_period (w_end_period)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_mode_nxt   = r_mode;
    w_rep_nxt    = r_rep;
    w_strobe_nxt = 1'b0;
    w_rep_inc    = (r_rep == REP_MAX) ? REP_MAX : (r_rep + REP_W'(1));
    case (r_state)
      IDLE: begin
        if (ENABLE) begin
          w_state_nxt  = HIGH;
          w_mode_nxt   = MODE_SEL;
          w_rep_nxt    = '0;
          w_strobe_nxt = 1'b1;
        end
      end
      HIGH: begin
        if (w_end_high) begin
          w_state_nxt = LOW;
        end
      end
      LOW: begin
        if (w_end_period) begin
          w_rep_nxt = w_rep_inc;
          // Stopping wins over a pending switch; the next start re-latches MODE_SEL anyway.
          if (!ENABLE) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt  = HIGH;
            w_strobe_nxt = 1'b1;
            if ((w_rep_inc == REP_MAX) && (MODE_SEL != r_mode)) begin
              w_mode_nxt = MODE_SEL;
              w_rep_nxt  = '0;
            end
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    w_aux_nxt  = (w_state_nxt == HIGH);
    w_busy_nxt = (w_state_nxt != IDLE) && (w_rep_nxt < REP_MAX);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= IDLE;
      r_mode   <= 1'b0;
      r_rep    <= '0;
      r_aux    <= 1'b0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mode   <= w_mode_nxt;
      r_rep    <= w_rep_nxt;
      r_aux    <= w_aux_nxt;
      r_strobe <= w_strobe_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign AUX_OUTPUT   = r_aux;
  assign MODE_ACTIVE  = r_mode;
  assign FRAME_STROBE = r_strobe;
  assign SWITCH_BUSY  = r_busy;

`ifdef PWM_TX_PULSE_COUNT_EN
  logic [15:0] r_pcnt;

  // A mode change always coincides with a frame start, so the new mode's first frame counts as 1.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pcnt <= '0;
    end else if (w_strobe_nxt) begin
      if (w_mode_nxt != r_mode) begin
        r_pcnt <= 16'd1;
      end else if (r_pcnt != 16'hFFFF) begin
        r_pcnt <= r_pcnt + 16'd1;
      end
    end
  end

  assign PULSE_COUNT = r_pcnt;
`endif

endmodule

// File: tb/tb_pwm_mode_transmitter.sv
// Directed bench for pwm_mode_transmitter with a shortened frame (200/50/150, 6 repeats).
module tb_pwm_mode_transmitter;

  logic clk;
  logic rst_n;
  logic en;
  logic msel;
  logic aux;
  logic mode;
  logic strobe;
  logic busy;
`ifdef PWM_TX_PULSE_COUNT_EN
  logic [15:0] pcnt;
`endif

  int n_assert;
  int n_fail;
  int hi;
  int len;
  int bz;

  pwm_mode_transmitter #(
    .PERIOD      (200),
    .SHORT_HIGH  (50),
    .LONG_HIGH   (150),
    .MIN_REPEATS (6),
    .CNT_W       (21)
  ) dut (
    .CLOCK_50     (clk),
    .RESET_N      (rst_n),
    .ENABLE       (en),
    .MODE_SEL     (msel),
    .AUX_OUTPUT   (aux),
    .MODE_ACTIVE  (mode),
    .FRAME_STROBE (strobe),
    .SWITCH_BUSY  (busy)
`ifdef PWM_TX_PULSE_COUNT_EN
    ,
    .PULSE_COUNT  (pcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called on a frame's first cycle; runs until the next FRAME_STROBE or 400 cycles.
  // A high cycle after a low one inflates hi by 1000 so a split pulse is caught.
  task automatic run_frame(input int drop_at, input int rise_at,
                           output int o_hi, output int o_len, output int o_bz);
    bit seen_low;
    o_hi = 0;
    o_len = 0;
    o_bz = 0;
    seen_low = 1'b0;
    do begin
      if (o_len == drop_at) en = 1'b0;
      if (o_len == rise_at) en = 1'b1;
      if (aux) begin
        o_hi++;
        if (seen_low) o_hi += 1000;
      end else begin
        seen_low = 1'b1;
      end
      if (busy) o_bz++;
      o_len++;
      tick();
    end while (!strobe && o_len < 400);
  endtask

  task automatic check_frame(input string tag, input int drop_at, input int rise_at,
                             input int hi_e, input int len_e, input int bz_e);
    run_frame(drop_at, rise_at, hi, len, bz);
    check({tag, "_high"}, hi, hi_e);
    check({tag, "_len"}, len, len_e);
    check({tag, "_busy"}, bz, bz_e);
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    rst_n = 1'b0;
    en = 1'b0;
    msel = 1'b0;
    repeat (3) tick();
    check("rst_aux", aux, 0);
    check("rst_mode", mode, 0);
    check("rst_strobe", strobe, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_aux", aux, 0);

    // Mode 0 start, then request mode 1 during frame 2
    en = 1'b1;
    check("b_pre_start_aux", aux, 0);
    tick();
    check("b_start_aux", aux, 1);
    check("b_start_strobe", strobe, 1);
    check("b_start_mode", mode, 0);
    check("b_start_busy", busy, 1);
    check_frame("b_f1", -1, -1, 50, 200, 200);
    msel = 1'b1;
    for (int f = 2; f <= 6; f++) begin
      check($sformatf("b_f%0d_mode", f), mode, 0);
      // Frame 3: ENABLE drops mid-frame and returns in the last low cycle
      if (f == 3) check_frame($sformatf("b_f%0d", f), 100, 199, 50, 200, 200);
      else        check_frame($sformatf("b_f%0d", f), -1, -1, 50, 200, 200);
    end
    check("b_f7_mode", mode, 1);
    check("b_f7_busy", busy, 1);
    for (int f = 7; f <= 11; f++) begin
      check_frame($sformatf("b_f%0d", f), -1, -1, 150, 200, 200);
    end
    check("b_f12_mode", mode, 1);
    check("b_f12_busy", busy, 1);
    check_frame("b_f12_drop", 20, -1, 150, 400, 200);
    check("b_idle_aux", aux, 0);
    check("b_idle_busy", busy, 0);
    check("b_idle_mode", mode, 1);

    // Restart re-latches MODE_SEL=0; busy clears from frame 7, then switch to mode 1
    msel = 1'b0;
    en = 1'b1;
    tick();
    check("c_start_aux", aux, 1);
    check("c_start_strobe", strobe, 1);
    check("c_start_mode", mode, 0);
    check("c_start_busy", busy, 1);
    for (int f = 1; f <= 6; f++) begin
      check_frame($sformatf("c_f%0d", f), -1, -1, 50, 200, 200);
    end
    check("c_f7_busy", busy, 0);
    check("c_f7_mode", mode, 0);
`ifdef PWM_TX_PULSE_COUNT_EN
    check("c_f7_pcnt", pcnt, 7);
`endif
    msel = 1'b1;
    check_frame("c_f7", -1, -1, 50, 200, 0);
    check("c_f8_mode", mode, 1);
    check("c_f8_busy", busy, 1);
`ifdef PWM_TX_PULSE_COUNT_EN
    check("c_f8_pcnt", pcnt, 1);
`endif

    // Asynchronous reset in the middle of a long pulse
    repeat (30) tick();
    check("d_pre_rst_aux", aux, 1);
    rst_n = 1'b0;
    #1;
    check("d_rst_aux", aux, 0);
    check("d_rst_mode", mode, 0);
    check("d_rst_busy", busy, 0);
    check("d_rst_strobe", strobe, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("d_start_aux", aux, 1);
    check("d_start_strobe", strobe, 1);
    check("d_start_mode", mode, 1);
    check_frame("d_f1", -1, -1, 150, 200, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
